// File: rtl/systolic_result_drain.sv
// Result-matrix unload stage: captures one full matrix from the array's parallel port and
// serializes it row-major, one element per cycle, into a valid/ready sink.
module systolic_result_drain #(
  parameter int unsigned width_p        = 32,
  parameter int unsigned array_width_p  = 2,
  parameter int unsigned array_height_p = 2,
  parameter int unsigned count_width_p  = 16
) (
  input  logic                                             clk_i,
  input  logic                                             reset_n_i,
  input  logic                                             en_i,
  input  logic [array_height_p*array_width_p*width_p-1:0] z_i,
  input  logic                                             z_valid_i,
  output logic                                             z_yumi_o,
  output logic                                             valid_o,
  input  logic                                             ready_i,
  output logic [width_p-1:0]                               data_o,
  output logic                                             last_o,
  output logic                                             busy_o,
  output logic [count_width_p-1:0]                         count_o
);

  localparam int unsigned N    = array_width_p * array_height_p;
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned BufW = N * width_p;

  localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StDrain = 1'b1;

  logic [0:0]               state_q, state_d;
  logic [IdxW-1:0]          idx_q, idx_d;
  logic [BufW-1:0]          buf_q, buf_d;
  logic [count_width_p-1:0] count_q, count_d;

  logic in_drain;
  logic at_last;
  logic xfer;
  logic final_xfer;
  logic capture;

  always_comb begin
    in_drain   = (state_q == StDrain);
    at_last    = (idx_q == LastIdx);
    xfer       = in_drain & ready_i;
    final_xfer = xfer & at_last;
    // Reset gates the handshake so nothing is consumed while the block is held in reset.
    capture    = reset_n_i & en_i & z_valid_i & (~in_drain | final_xfer);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    count_d = count_q;

    if (final_xfer) begin
      count_d = count_q + count_width_p'(1);
    end

    if (capture) begin
      // Reload on the final handshake as well, giving back-to-back matrices with no bubble.
      buf_d   = z_i;
      idx_d   = '0;
      state_d = StDrain;
    end else if (final_xfer) begin
      state_d = StIdle;
    end else if (xfer) begin
      idx_d = idx_q + IdxW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= StIdle;
      idx_q   <= '0;
      buf_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    z_yumi_o = capture;
    valid_o  = in_drain;
    busy_o   = in_drain;
    last_o   = in_drain & at_last;
    data_o   = in_drain ? buf_q[idx_q*width_p +: width_p] : '0;
    count_o  = count_q;
  end

endmodule

// File: tb/tb_systolic_result_drain.sv
// Randomized and directed bench for systolic_result_drain against a queue-based reference model.
module tb_systolic_result_drain;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int CW = 16;
  localparam logic [N*W-1:0] Z1 = {32'd4, 32'd3, 32'd2, 32'd1};
  localparam logic [N*W-1:0] Z2 = {32'd8, 32'd7, 32'd6, 32'd5};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Main 2x2 instance
  logic           en, zv, rdy;
  logic [N*W-1:0] z;
  logic           yumi, valid, last, busy;
  logic [W-1:0]   data;
  logic [CW-1:0]  count;

  // 1x1 instance with a 2-bit counter
  logic       w_en, w_zv, w_rdy;
  logic [7:0] w_z;
  logic       w_yumi, w_valid, w_last, w_busy;
  logic [7:0] w_data;
  logic [1:0] w_count;

  systolic_result_drain #(
    .width_p(W), .array_width_p(2), .array_height_p(2), .count_width_p(CW)
  ) u_dut (
    .clk_i(clk), .reset_n_i(rst_n), .en_i(en), .z_i(z), .z_valid_i(zv), .z_yumi_o(yumi),
    .valid_o(valid), .ready_i(rdy), .data_o(data), .last_o(last), .busy_o(busy),
    .count_o(count)
  );

  systolic_result_drain #(
    .width_p(8), .array_width_p(1), .array_height_p(1), .count_width_p(2)
  ) u_wrap (
    .clk_i(clk), .reset_n_i(rst_n), .en_i(w_en), .z_i(w_z), .z_valid_i(w_zv),
    .z_yumi_o(w_yumi), .valid_o(w_valid), .ready_i(w_rdy), .data_o(w_data), .last_o(w_last),
    .busy_o(w_busy), .count_o(w_count)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: words still owed to the sink, and matrices fully delivered.
  logic [W-1:0]  mq[$];
  logic [CW-1:0] mcnt;
  logic          exp_yumi, exp_valid, exp_last;
  logic [51:0]   exp_v, obs_v;

  task automatic drive(input logic e, input logic v, input logic [N*W-1:0] zz, input logic r);
    logic [W-1:0] d;
    @(negedge clk);
    en = e; zv = v; z = zz; rdy = r;
    #1;
    exp_valid = (mq.size() > 0);
    exp_last  = (mq.size() == 1);
    exp_yumi  = rst_n & e & v & ((mq.size() == 0) | (exp_last & r));
    d         = exp_valid ? mq[0] : '0;
    exp_v     = {exp_yumi, exp_valid, exp_last, exp_valid, d, mcnt};
    obs_v     = {yumi, valid, last, busy, data, count};
  endtask

  task automatic advance();
    @(posedge clk);
    if (exp_valid && rdy) begin
      void'(mq.pop_front());
      if (exp_last) mcnt = mcnt + 1'b1;
    end
    if (exp_yumi) begin
      for (int k = 0; k < N; k++) mq.push_back(z[k*W +: W]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en = 1'b1; zv = 1'b1; z = Z1; rdy = 1'b1;
    w_en = 1'b0; w_zv = 1'b0; w_z = '0; w_rdy = 1'b1;
    mq.delete();
    mcnt = '0;
    #1;
    vectors++;
    if ({yumi, valid, last, busy, data, count} !== 52'h0) begin
      $display("FAIL reset_main got=%h exp=0", {yumi, valid, last, busy, data, count});
      miscompares++;
    end
    vectors++;
    if ({w_yumi, w_valid, w_last, w_busy, w_data, w_count} !== 14'h0) begin
      $display("FAIL reset_wrap got=%h exp=0", {w_yumi, w_valid, w_last, w_busy, w_data, w_count});
      miscompares++;
    end
    @(posedge clk);
    @(negedge clk);
    zv = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, (i == 0), Z1, 1'b1);
      vectors++;
      if (obs_v !== exp_v) begin
        $display("FAIL basic cyc=%0d got=%h exp=%h", i, obs_v, exp_v);
        miscompares++;
      end
      advance();
    end
    @(negedge clk);
    #1;
    vectors++;
    if (count !== 16'd1 || busy !== 1'b0) begin
      $display("FAIL basic_done count=%0d busy=%b exp count=1 busy=0", count, busy);
      miscompares++;
    end
  endtask

  task automatic test_backpressure();
    int rp[7] = '{1, 0, 0, 1, 0, 1, 1};
    for (int i = 0; i < 9; i++) begin
      if (i == 0) drive(1'b1, 1'b1, Z1, 1'b0);
      else if (i <= 7) drive(1'b1, 1'b0, Z1, rp[i-1][0]);
      else drive(1'b1, 1'b0, Z1, 1'b1);
      vectors++;
      if (obs_v !== exp_v) begin
        $display("FAIL backpressure cyc=%0d got=%h exp=%h", i, obs_v, exp_v);
        miscompares++;
      end
      advance();
    end
  endtask

  task automatic test_back_to_back();
    logic [CW-1:0] c0;
    c0 = mcnt;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, (i <= 4), (i == 0) ? Z1 : Z2, 1'b1);
      vectors++;
      if (obs_v !== exp_v) begin
        $display("FAIL back_to_back cyc=%0d got=%h exp=%h", i, obs_v, exp_v);
        miscompares++;
      end
      if (i >= 1 && i <= 8) begin
        vectors++;
        if (valid !== 1'b1 || data !== W'(i)) begin
          $display("FAIL b2b_stream cyc=%0d valid=%b data=%0d exp valid=1 data=%0d",
                   i, valid, data, i);
          miscompares++;
        end
      end
      advance();
    end
    @(negedge clk);
    #1;
    vectors++;
    if (count !== c0 + 16'd2) begin
      $display("FAIL b2b_count got=%0d exp=%0d", count, c0 + 16'd2);
      miscompares++;
    end
  endtask

  task automatic test_enable();
    for (int i = 0; i < 13; i++) begin
      if (i < 5) drive(1'b0, 1'b1, Z2, 1'b1);
      else if (i == 5) drive(1'b1, 1'b1, Z2, 1'b1);
      else if (i < 8) drive(1'b1, 1'b0, Z1, 1'b1);
      else drive(1'b0, 1'b1, Z1, 1'b1);
      vectors++;
      if (obs_v !== exp_v) begin
        $display("FAIL enable cyc=%0d got=%h exp=%h", i, obs_v, exp_v);
        miscompares++;
      end
      advance();
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, (i == 0) || (i == 3), Z1, 1'b1);
      vectors++;
      if (obs_v !== exp_v) begin
        $display("FAIL reset_mid_pre cyc=%0d got=%h exp=%h", i, obs_v, exp_v);
        miscompares++;
      end
      if (i < 3) advance();
    end
    rst_n = 1'b0;
    mq.delete();
    mcnt = '0;
    #1;
    vectors++;
    if ({yumi, valid, last, busy, count} !== 20'h0) begin
      $display("FAIL reset_mid got yumi=%b valid=%b last=%b busy=%b count=%0d exp all 0",
               yumi, valid, last, busy, count);
      miscompares++;
    end
    @(posedge clk);
    @(negedge clk);
    zv = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, Z2, 1'b1);
      vectors++;
      if (obs_v !== exp_v) begin
        $display("FAIL reset_mid_post cyc=%0d got=%h exp=%h", i, obs_v, exp_v);
        miscompares++;
      end
      advance();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 7) != 0), $urandom_range(0, 1) == 1,
            {$urandom, $urandom, $urandom, $urandom}, ($urandom_range(0, 3) != 0));
      vectors++;
      if (obs_v !== exp_v) begin
        $display("FAIL random cyc=%0d got=%h exp=%h", i, obs_v, exp_v);
        miscompares++;
      end
      advance();
    end
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b0, '0, 1'b1);
      vectors++;
      if (obs_v !== exp_v) begin
        $display("FAIL random_flush cyc=%0d got=%h exp=%h", i, obs_v, exp_v);
        miscompares++;
      end
      advance();
    end
  endtask

  task automatic test_wrap();
    logic [7:0]  wq[$];
    logic [1:0]  wcnt;
    logic        ey, ev, pend;
    logic [13:0] e_w, o_w;
    int          exp_seq[5] = '{1, 2, 3, 0, 1};
    int          j;
    wcnt = '0;
    pend = 1'b0;
    j    = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      w_en = 1'b1; w_zv = (i < 5); w_z = 8'($urandom); w_rdy = 1'b1;
      #1;
      ev  = (wq.size() > 0);
      ey  = rst_n & w_en & w_zv & ((wq.size() == 0) | ((wq.size() == 1) & w_rdy));
      e_w = {ey, ev, ev, ev, ev ? wq[0] : 8'h00, wcnt};
      o_w = {w_yumi, w_valid, w_last, w_busy, w_data, w_count};
      vectors++;
      if (o_w !== e_w) begin
        $display("FAIL wrap cyc=%0d got=%h exp=%h", i, o_w, e_w);
        miscompares++;
      end
      if (pend) begin
        vectors++;
        if (w_count !== exp_seq[j][1:0]) begin
          $display("FAIL wrap_seq idx=%0d got=%0d exp=%0d", j, w_count, exp_seq[j]);
          miscompares++;
        end
        j++;
      end
      @(posedge clk);
      pend = 1'b0;
      if (ev && w_rdy) begin
        void'(wq.pop_front());
        wcnt = wcnt + 1'b1;
        pend = (j < 5);
      end
      if (ey) wq.push_back(w_z);
    end
    w_en = 1'b0;
    w_zv = 1'b0;
    vectors++;
    if (j != 5) begin
      $display("FAIL wrap_total got=%0d completions exp=5", j);
      miscompares++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_enable();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/systolic_result_drain.md
Name: systolic_result_drain

Overview:
- Unload side of the systolic array datapath.
- Accepts one complete result matrix from the array's parallel result port (z valid/yumi). Holds it in a local buffer and serializes it, row-major, one word per cycle, into the output FIFO's write port (valid/ready).
- Supports back-to-back matrices with no bubble. Reports busy status and a count of completed matrices.

Parameters:
- width_p, 32, bits per result element.
- array_width_p, 2, columns in the result matrix.
- array_height_p, 2, rows in the result matrix.
- count_width_p, 16, width of the completed-matrix counter.

Ports:
- clk_i  input  1  single clock; all state on rising edge.
- reset_n_i  input  1  asynchronous, active-low reset.
- en_i  input  1  capture enable; gates acceptance of new matrices only.
- z_i  input  array_height_p*array_width_p*width_p  flat result matrix; element (r,c) at bits [(r*array_width_p+c)*width_p +: width_p].
- z_valid_i  input  1  array presents a complete result on z_i.
- z_yumi_o  output  1  matrix consumed this cycle.
- valid_o  output  1  data_o holds a word for the output FIFO.
- ready_i  input  1  output FIFO can accept a word.
- data_o  output  width_p  serialized element.
- last_o  output  1  data_o is the final element (index N-1) of its matrix.
- busy_o  output  1  a drain is in progress.
- count_o  output  count_width_p  matrices fully drained since reset; wraps modulo 2^count_width_p.

Behaviour:
- N = array_width_p*array_height_p. Element index k = r*array_width_p + c. Emission order is k = 0..N-1.
- Reset (asynchronous assert, synchronous release):
  - state=IDLE, idx=0, buffer=0, count_o=0.
  - valid_o=0, last_o=0, z_yumi_o=0, busy_o=0, data_o=0.
- States: IDLE, DRAIN.
- capture = en_i & z_valid_i & (state==IDLE | (state==DRAIN & final_xfer)).
  - z_yumi_o = capture. It is combinational and is never asserted without z_valid_i.
- On capture, z_i is registered into the buffer, idx is set to 0 and state goes to DRAIN.
- IDLE: valid_o=0, data_o=0, last_o=0, busy_o=0.
  - If capture, go to DRAIN. Otherwise stay in IDLE.
- DRAIN: valid_o=1, busy_o=1, data_o=buffer[idx], last_o=(idx==N-1).
  - xfer = valid_o & ready_i.
  - xfer with idx<N-1: idx increments.
  - final_xfer = xfer & idx==N-1. On final_xfer:
    - count_o increments (wraps).
    - If capture: reload the buffer, idx=0, stay in DRAIN (back-to-back, no bubble cycle).
    - Otherwise go to IDLE.
  - ready_i=0: idx, data_o, last_o and valid_o hold stable. valid_o never drops before its handshake.
- Latency: capture in cycle T gives the first valid_o in cycle T+1. With ready_i held high, one matrix takes exactly N cycles of valid_o.
- Throughput: with ready_i and z_valid_i held high, valid_o stays continuously high and one matrix completes every N cycles.
- en_i=0:
  - No new capture and z_yumi_o=0.
  - A drain already in progress completes normally.
- z_valid_i during DRAIN before the final word: not accepted, z_yumi_o=0. z_i may change freely because the buffer is isolated.
- Reset mid-drain: the partial matrix is discarded, there is no further output, and count_o is not incremented.
- N=1 (1x1 array): every DRAIN word has last_o=1, and back-to-back capture gives one matrix per cycle.

Test Plan:
- Basic drain, 2x2:
  - Stimulus: z_i={4,3,2,1} (k3..k0), z_valid_i=1 for one cycle, en_i=1, ready_i=1.
  - Required: z_yumi_o pulses in the same cycle. data_o=1,2,3,4 on the next 4 cycles. last_o only with 4. count_o=1, then busy_o=0.
- Backpressure:
  - Stimulus: same matrix, ready_i toggling 1,0,0,1,0,1,1.
  - Required: data_o/valid_o stable during stalls. Sequence is 1,2,3,4 with no loss or duplication. last_o is held with 4 until accepted.
- Back-to-back:
  - Stimulus: z_valid_i held high with z_i={4,3,2,1} then {8,7,6,5}, ready_i=1.
  - Required: second z_yumi_o in the same cycle as the handshake on 4. Output 1..8 with valid_o continuously high. count_o=2.
- Enable gating:
  - Stimulus: en_i=0 with z_valid_i=1 for 5 cycles, then en_i=1.
  - Required: z_yumi_o=0 and valid_o=0 while en_i=0. Capture occurs in the first cycle with en_i=1.
  - Also: clearing en_i mid-drain still completes all 4 words.
- Reset mid-drain:
  - Stimulus: assert reset_n_i=0 asynchronously after word 2 of a matrix.
  - Required: valid_o, busy_o, last_o, z_yumi_o go to 0 immediately. count_o=0. After release, no stale words are emitted.
- Counter wrap:
  - Stimulus: count_width_p=2, drain 5 matrices.
  - Required: count_o sequence 1,2,3,0,1.
